// File: rtl/drive_setpt_sequencer.sv
// rtl/drive_setpt_sequencer.sv - two-wheel drive setpoint ramp sequencer
// Each channel ramps at a fixed tick rate and dwells at zero before any direction reversal.
module drive_setpt_sequencer #(
    parameter int TICK_DIV    = 50000,
    parameter int STEP        = 4,
    parameter int DWELL_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       estop,
    input  logic [7:0] req_setptL,
    input  logic [7:0] req_setptR,
    output logic [7:0] setptL,
    output logic [7:0] setptR,
    output logic       settled
);

    typedef enum logic [1:0] {RUN, RAMP_DN, DWELL} ch_state_t;

    localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [6:0]  STEP_M     = 7'(STEP);
    localparam logic [15:0] DWELL_INIT = 16'(DWELL_TICKS);

    logic [15:0] tick_cnt;
    logic        tick;

    ch_state_t   state_q [2];
    ch_state_t   state_d [2];
    logic        dir_q   [2];
    logic        dir_d   [2];
    logic [6:0]  mag_q   [2];
    logic [6:0]  mag_d   [2];
    logic [15:0] dwell_q [2];
    logic [15:0] dwell_d [2];
    logic [6:0]  dn_c    [2];
    logic [7:0]  raw     [2];
    logic [7:0]  req_c   [2];
    logic [7:0]  out_d   [2];
    logic [7:0]  setpt_q [2];
    logic        settled_d;

    function automatic logic [6:0] min_step(input logic [6:0] d);
        return (d > STEP_M) ? STEP_M : d;
    endfunction

    // Moves toward the target by at most STEP; the clamp makes overshoot impossible.
    function automatic logic [6:0] toward(input logic [6:0] c, input logic [6:0] t);
        if (t > c)
            return c + min_step(t - c);
        else
            return c - min_step(c - t);
    endfunction

    assign tick   = (tick_cnt == TICK_LAST);
    assign raw[0] = req_setptL;
    assign raw[1] = req_setptR;
    assign setptL = setpt_q[0];
    assign setptR = setpt_q[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req_c[i]   = (!en || raw[i][6:0] == 7'd0) ? 8'h00 : raw[i];
            state_d[i] = state_q[i];
            dir_d[i]   = dir_q[i];
            mag_d[i]   = mag_q[i];
            dwell_d[i] = dwell_q[i];
            dn_c[i]    = mag_q[i] - min_step(mag_q[i]);
            if (tick) begin
                case (state_q[i])
                    RUN: begin
                        if (mag_q[i] == 7'd0) begin
                            dir_d[i] = req_c[i][7];
                            mag_d[i] = toward(7'd0, req_c[i][6:0]);
                        end else if (req_c[i][7] == dir_q[i]) begin
                            mag_d[i] = toward(mag_q[i], req_c[i][6:0]);
                        end else begin
                            mag_d[i]   = dn_c[i];
                            state_d[i] = (dn_c[i] == 7'd0) ? DWELL : RAMP_DN;
                            dwell_d[i] = DWELL_INIT;
                        end
                    end
                    RAMP_DN: begin
                        if (req_c[i][7] == dir_q[i]) begin
                            state_d[i] = RUN;
                            mag_d[i]   = toward(mag_q[i], req_c[i][6:0]);
                        end else begin
                            mag_d[i]   = dn_c[i];
                            state_d[i] = (dn_c[i] == 7'd0) ? DWELL : RAMP_DN;
                            dwell_d[i] = DWELL_INIT;
                        end
                    end
                    DWELL: begin
                        if (dwell_q[i] == 16'd0) begin
                            dir_d[i]   = req_c[i][7];
                            state_d[i] = RUN;
                        end else begin
                            dwell_d[i] = dwell_q[i] - 16'd1;
                        end
                    end
                    default: state_d[i] = RUN;
                endcase
            end
            out_d[i] = (mag_d[i] != 7'd0) ? {dir_d[i], mag_d[i]} : 8'h00;
        end
        settled_d = (state_d[0] == RUN) && (state_d[1] == RUN) &&
                    (out_d[0] == req_c[0]) && (out_d[1] == req_c[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= 16'd0;
            settled  <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= RUN;
                dir_q[i]   <= 1'b0;
                mag_q[i]   <= 7'd0;
                dwell_q[i] <= 16'd0;
                setpt_q[i] <= 8'h00;
            end
        end else begin
            tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
            if (estop) begin
                settled <= 1'b0;
                for (int i = 0; i < 2; i++) begin
                    state_q[i] <= RUN;
                    dir_q[i]   <= 1'b0;
                    mag_q[i]   <= 7'd0;
                    dwell_q[i] <= 16'd0;
                    setpt_q[i] <= 8'h00;
                end
            end else begin
                settled <= settled_d;
                for (int i = 0; i < 2; i++) begin
                    state_q[i] <= state_d[i];
                    dir_q[i]   <= dir_d[i];
                    mag_q[i]   <= mag_d[i];
                    dwell_q[i] <= dwell_d[i];
                    setpt_q[i] <= out_d[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_drive_setpt_sequencer.sv
// tb/tb_drive_setpt_sequencer.sv - self-checking bench for drive_setpt_sequencer
// Directed ramp/reversal/estop sequences plus randomized traffic against a behavioural model.
module tb_drive_setpt_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int STEP        = 8;
    localparam int DWELL_TICKS = 2;
    localparam int M_RUN = 0, M_DOWN = 1, M_DWELL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       estop = 1'b0;
    logic [7:0] req_setptL = 8'h00;
    logic [7:0] req_setptR = 8'h00;
    logic [7:0] setptL;
    logic [7:0] setptR;
    logic       settled;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt = 0;
    bit m_tick = 1'b0;
    int m_mode [2];
    int m_dir  [2];
    int m_mag  [2];
    int m_dwell[2];
    bit exp_settled = 1'b1;

    logic [7:0] ramp_tbl [5]  = '{8'h08, 8'h10, 8'h18, 8'h20, 8'h28};
    logic [7:0] rev_tbl  [13] = '{8'h20, 8'h18, 8'h10, 8'h08, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'h88, 8'h90, 8'h98, 8'hA0, 8'hA8};
    logic [7:0] abort_tbl[6]  = '{8'h20, 8'h18, 8'h10, 8'h18, 8'h20, 8'h28};
    logic [7:0] down_tbl [5]  = '{8'h20, 8'h18, 8'h10, 8'h08, 8'h00};

    drive_setpt_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .STEP       (STEP),
        .DWELL_TICKS(DWELL_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .estop     (estop),
        .req_setptL(req_setptL),
        .req_setptR(req_setptR),
        .setptL    (setptL),
        .setptR    (setptR),
        .settled   (settled)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int canon(input int r, input bit e);
        return (!e || (r % 128) == 0) ? 0 : r;
    endfunction

    function automatic int toward(input int c, input int t);
        return (t > c) ? c + imin(STEP, t - c) : c - imin(STEP, c - t);
    endfunction

    function automatic int out_of(input int i);
        return (m_mag[i] != 0) ? m_dir[i] * 128 + m_mag[i] : 0;
    endfunction

    task automatic clear_chan(input int i);
        m_mode[i] = M_RUN; m_dir[i] = 0; m_mag[i] = 0; m_dwell[i] = 0;
    endtask

    task automatic shrink(input int i);
        m_mag[i] = m_mag[i] - imin(STEP, m_mag[i]);
        if (m_mag[i] == 0) begin
            m_mode[i]  = M_DWELL;
            m_dwell[i] = DWELL_TICKS;
        end else begin
            m_mode[i] = M_DOWN;
        end
    endtask

    task automatic chan_tick(input int i, input int r);
        int rdir;
        int rmag;
        rdir = r / 128;
        rmag = r % 128;
        if (m_mode[i] == M_DWELL) begin
            if (m_dwell[i] == 0) begin
                m_dir[i]  = rdir;
                m_mode[i] = M_RUN;
            end else begin
                m_dwell[i]--;
            end
        end else if (m_mode[i] == M_RUN && m_mag[i] == 0) begin
            m_dir[i] = rdir;
            m_mag[i] = toward(0, rmag);
        end else if (rdir == m_dir[i]) begin
            m_mode[i] = M_RUN;
            m_mag[i]  = toward(m_mag[i], rmag);
        end else begin
            shrink(i);
        end
    endtask

    task automatic model_edge();
        int r[2];
        r[0] = canon(int'(req_setptL), en);
        r[1] = canon(int'(req_setptR), en);
        m_tick = 1'b0;
        if (rst) begin
            m_cnt = 0;
            clear_chan(0);
            clear_chan(1);
            exp_settled = 1'b1;
        end else begin
            m_tick = (m_cnt == TICK_DIV - 1);
            m_cnt  = (m_cnt + 1) % TICK_DIV;
            if (estop) begin
                clear_chan(0);
                clear_chan(1);
                exp_settled = 1'b0;
            end else begin
                if (m_tick) begin
                    chan_tick(0, r[0]);
                    chan_tick(1, r[1]);
                end
                exp_settled = (m_mode[0] == M_RUN) && (m_mode[1] == M_RUN) &&
                              (out_of(0) == r[0]) && (out_of(1) == r[1]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("model_setptL", setptL, out_of(0));
        check("model_setptR", setptR, out_of(1));
        check("model_settled", settled, exp_settled);
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!m_tick && k < TICK_DIV + 1);
        if (!m_tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_wait: no tick within %0d cycles", k);
        end
    endtask

    function automatic logic [7:0] rand_req();
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_chan(0);
        clear_chan(1);
        // Reset with arbitrary requests applied
        rst = 1'b1; req_setptL = 8'hA8; req_setptR = 8'h37;
        cycle();
        cycle();
        check("reset_setptL", setptL, 8'h00);
        check("reset_setptR", setptR, 8'h00);
        check("reset_settled", settled, 1'b1);

        // Ramp up both channels
        rst = 1'b0; req_setptL = 8'h28; req_setptR = 8'h28;
        for (int k = 0; k < 5; k++) begin
            wait_tick();
            check("ramp_up_L", setptL, ramp_tbl[k]);
            check("ramp_up_R", setptR, ramp_tbl[k]);
            if (k == 3) check("ramp_unsettled", settled, 1'b0);
        end
        check("ramp_settled", settled, 1'b1);

        // Reversal with dwell on L only
        req_setptL = 8'hA8;
        for (int k = 0; k < 13; k++) begin
            wait_tick();
            check("reverse_L", setptL, rev_tbl[k]);
            check("reverse_R", setptR, 8'h28);
        end

        // Return L forward, then abort a reversal mid ramp-down
        req_setptL = 8'h28;
        for (int k = 0; k < 14; k++) wait_tick();
        check("forward_L", setptL, 8'h28);
        req_setptL = 8'hA8;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) req_setptL = 8'h28;
            wait_tick();
            check("abort_L", setptL, abort_tbl[k]);
        end

        // Emergency stop and restart
        estop = 1'b1;
        cycle();
        check("estop_L", setptL, 8'h00);
        check("estop_R", setptR, 8'h00);
        check("estop_settled", settled, 1'b0);
        for (int k = 0; k < 6; k++) cycle();
        check("estop_hold_L", setptL, 8'h00);
        estop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_tick();
            check("restart_L", setptL, ramp_tbl[k]);
            check("restart_R", setptR, ramp_tbl[k]);
        end

        // Ramp to zero without dwell, small step, then en=0
        req_setptL = 8'h00; req_setptR = 8'h00;
        for (int k = 0; k < 5; k++) begin
            wait_tick();
            check("down_L", setptL, down_tbl[k]);
        end
        req_setptL = 8'h05;
        wait_tick();
        check("small_step_L", setptL, 8'h05);
        en = 1'b0;
        wait_tick();
        check("en_off_L", setptL, 8'h00);
        en = 1'b1;

        // Reset in the middle of a reversal
        req_setptL = 8'h28;
        for (int k = 0; k < 5; k++) wait_tick();
        req_setptL = 8'hA8;
        wait_tick();
        wait_tick();
        rst = 1'b1;
        cycle();
        check("mid_reset_L", setptL, 8'h00);
        check("mid_reset_settled", settled, 1'b1);
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 11) == 0) req_setptL = rand_req();
            if ($urandom_range(0, 11) == 0) req_setptR = rand_req();
            if ($urandom_range(0, 59) == 0) estop = 1'b1;
            else if (estop && $urandom_range(0, 3) == 0) estop = 1'b0;
            if ($urandom_range(0, 49) == 0) en = ~en;
            rst = ($urandom_range(0, 249) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
